// File: rtl/sipo_rx.sv
`default_nettype none
// ============================================================================
// Module      : sipo_rx
// Description : UART receive shift register. Oversampled start/data/parity/
//               stop framing with a valid/acknowledge handshake to the bus.
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 baud_clk,
    input  logic                 reset,
    input  logic                 data_rx,
    input  logic                 parity_type,
    input  logic                 rd_ack,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 done_flag,
    output logic                 active_flag,
    output logic                 parity_error,
    output logic                 framing_error,
    output logic                 overrun_error,
    output logic [3:0]           bit_count
);

    localparam int               c_TICK_W    = $clog2(OVERSAMPLE);
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(OVERSAMPLE - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_HALF = c_TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]       c_LAST_BIT  = 4'(DATA_BITS - 1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP   = 3'd4;

    logic                 r_sync1;
    logic                 r_sync2;
    logic [2:0]           r_state;
    logic [2:0]           w_state_next;
    logic [c_TICK_W-1:0]  r_tick_cnt;
    logic [DATA_BITS-1:0] r_shift_reg;
    logic                 r_par_err;
    logic                 w_rx_s;
    logic                 w_tick_last;
    logic                 w_tick_half;
    logic                 w_frame_done;

    assign w_rx_s      = r_sync2;
    assign w_tick_last = (r_tick_cnt == c_TICK_LAST);
    assign w_tick_half = (r_tick_cnt == c_TICK_HALF);
    assign active_flag = (r_state != c_ST_IDLE);

    // Two-flop synchronizer; resets to the idle line level.
    always_ff @(posedge baud_clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= data_rx;
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_frame_done = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (!w_rx_s) w_state_next = c_ST_START;
            end
            c_ST_START: begin
                if (w_tick_half) w_state_next = w_rx_s ? c_ST_IDLE : c_ST_DATA;
            end
            c_ST_DATA: begin
                if (w_tick_last && (bit_count == c_LAST_BIT)) w_state_next = c_ST_PARITY;
            end
            c_ST_PARITY: begin
                if (w_tick_last) w_state_next = c_ST_STOP;
            end
            c_ST_STOP: begin
                // Leaving at mid stop bit leaves time to catch a back-to-back start.
                if (w_tick_last) begin
                    w_state_next = c_ST_IDLE;
                    w_frame_done = 1'b1;
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge baud_clk) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_tick_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if ((w_state_next != r_state) || (r_state == c_ST_IDLE) || w_tick_last)
                r_tick_cnt <= '0;
            else
                r_tick_cnt <= r_tick_cnt + c_TICK_W'(1);
        end
    end

    always_ff @(posedge baud_clk) begin
        if (reset) begin
            r_shift_reg <= '0;
            bit_count   <= '0;
            r_par_err   <= 1'b0;
        end else begin
            if ((r_state == c_ST_START) && (w_state_next == c_ST_DATA))
                bit_count <= '0;
            if ((r_state == c_ST_DATA) && w_tick_last) begin
                r_shift_reg <= {w_rx_s, r_shift_reg[DATA_BITS-1:1]};
                bit_count   <= bit_count + 4'd1;
            end
            if ((r_state == c_ST_PARITY) && w_tick_last)
                r_par_err <= w_rx_s ^ (^r_shift_reg) ^ parity_type;
        end
    end

    always_ff @(posedge baud_clk) begin
        if (reset) begin
            data_out      <= '0;
            data_valid    <= 1'b0;
            done_flag     <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
        end else if (w_frame_done) begin
            data_out      <= r_shift_reg;
            parity_error  <= r_par_err;
            framing_error <= !w_rx_s;
            done_flag     <= 1'b1;
            overrun_error <= overrun_error | (data_valid & !rd_ack);
            data_valid    <= 1'b1;
        end else begin
            done_flag <= 1'b0;
            if (rd_ack && data_valid) data_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sipo_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_sipo_rx
// Description : Directed self-checking bench for sipo_rx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sipo_rx;

    localparam int c_OS = 16;

    logic       clk;
    logic       rst;
    logic       r_data_rx;
    logic       r_parity_type;
    logic       r_rd_ack;
    logic [7:0] w_data_out;
    logic       w_data_valid;
    logic       w_done_flag;
    logic       w_active_flag;
    logic       w_parity_error;
    logic       w_framing_error;
    logic       w_overrun_error;
    logic [3:0] w_bit_count;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt = 0;
    int act_cnt = 0;
    int last_done_cyc = 0;

    sipo_rx #(.OVERSAMPLE(c_OS), .DATA_BITS(8)) dut (
        .baud_clk      (clk),
        .reset         (rst),
        .data_rx       (r_data_rx),
        .parity_type   (r_parity_type),
        .rd_ack        (r_rd_ack),
        .data_out      (w_data_out),
        .data_valid    (w_data_valid),
        .done_flag     (w_done_flag),
        .active_flag   (w_active_flag),
        .parity_error  (w_parity_error),
        .framing_error (w_framing_error),
        .overrun_error (w_overrun_error),
        .bit_count     (w_bit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (w_done_flag) begin
            done_cnt      <= done_cnt + 1;
            last_done_cyc <= cyc;
        end
        if (w_active_flag) act_cnt <= act_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        r_data_rx = b;
        repeat (c_OS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(par);
        drive_bit(stop);
        r_data_rx = 1'b1;
    endtask

    task automatic ack;
        r_rd_ack = 1'b1;
        @(negedge clk);
        r_rd_ack = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int d0;
        int a0;
        int t0;
        rst           = 1'b1;
        r_data_rx     = 1'b1;
        r_parity_type = 1'b0;
        r_rd_ack      = 1'b0;
        repeat (4) @(negedge clk);

        chk("rst_data_out", {24'd0, w_data_out}, 32'h0);
        chk("rst_valid", {31'd0, w_data_valid}, 32'h0);
        chk("rst_done", {31'd0, w_done_flag}, 32'h0);
        chk("rst_active", {31'd0, w_active_flag}, 32'h0);
        chk("rst_errs", {29'd0, w_parity_error, w_framing_error, w_overrun_error}, 32'h0);
        chk("rst_bitcnt", {28'd0, w_bit_count}, 32'h0);

        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 1: 0xA5 even parity, latency check
        d0 = done_cnt;
        t0 = cyc;
        send_frame(8'hA5, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        chk("t1_done_cnt", done_cnt - d0, 1);
        chk("t1_latency_ok", {31'd0, ((last_done_cyc - t0) >= 170) && ((last_done_cyc - t0) <= 171)}, 1);
        chk("t1_data", {24'd0, w_data_out}, 32'hA5);
        chk("t1_valid", {31'd0, w_data_valid}, 1);
        chk("t1_perr", {31'd0, w_parity_error}, 0);
        chk("t1_ferr", {31'd0, w_framing_error}, 0);
        ack();
        chk("t1_ack_valid", {31'd0, w_data_valid}, 0);
        chk("t1_ovr", {31'd0, w_overrun_error}, 0);

        // 2: 0x01 odd parity, right then wrong parity bit
        r_parity_type = 1'b1;
        send_frame(8'h01, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        chk("t2a_perr", {31'd0, w_parity_error}, 0);
        chk("t2a_data", {24'd0, w_data_out}, 32'h01);
        ack();
        send_frame(8'h01, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        chk("t2b_perr", {31'd0, w_parity_error}, 1);
        chk("t2b_data", {24'd0, w_data_out}, 32'h01);
        ack();
        r_parity_type = 1'b0;

        // 3: 0xFF with stop bit low
        send_frame(8'hFF, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        chk("t3_ferr", {31'd0, w_framing_error}, 1);
        chk("t3_perr", {31'd0, w_parity_error}, 0);
        chk("t3_data", {24'd0, w_data_out}, 32'hFF);
        chk("t3_valid", {31'd0, w_data_valid}, 1);
        ack();
        repeat (10) @(negedge clk);

        // 4: 5-cycle glitch is rejected as a false start
        d0 = done_cnt;
        a0 = act_cnt;
        r_data_rx = 1'b0;
        repeat (5) @(negedge clk);
        r_data_rx = 1'b1;
        repeat (30) @(negedge clk);
        chk("t4_active_cycles", act_cnt - a0, 8);
        chk("t4_no_done", done_cnt - d0, 0);
        chk("t4_valid", {31'd0, w_data_valid}, 0);
        chk("t4_idle", {31'd0, w_active_flag}, 0);

        // 5: back-to-back frames without acknowledge
        d0 = done_cnt;
        send_frame(8'h3C, 1'b0, 1'b1);
        chk("t5_ovr_first", {31'd0, w_overrun_error}, 0);
        send_frame(8'hC3, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        chk("t5_done_cnt", done_cnt - d0, 2);
        chk("t5_data", {24'd0, w_data_out}, 32'hC3);
        chk("t5_ovr", {31'd0, w_overrun_error}, 1);
        ack();
        chk("t5_ack_valid", {31'd0, w_data_valid}, 0);
        chk("t5_ovr_sticky", {31'd0, w_overrun_error}, 1);

        // 6: reset during data bit 4, then a clean 0x5A
        d0 = done_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'(8'h5A >> i));
        r_data_rx = 1'b1;
        repeat (8) @(negedge clk);
        chk("t6_mid_bitcnt", {28'd0, w_bit_count}, 4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_rst_active", {31'd0, w_active_flag}, 0);
        chk("t6_rst_bitcnt", {28'd0, w_bit_count}, 0);
        chk("t6_rst_data", {24'd0, w_data_out}, 0);
        chk("t6_rst_errs", {28'd0, w_data_valid, w_parity_error, w_framing_error, w_overrun_error}, 0);
        repeat (40) @(negedge clk);
        chk("t6_abort_no_done", done_cnt - d0, 0);
        send_frame(8'h5A, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        chk("t6_done_cnt", done_cnt - d0, 1);
        chk("t6_data", {24'd0, w_data_out}, 32'h5A);
        chk("t6_valid", {31'd0, w_data_valid}, 1);
        chk("t6_errs", {29'd0, w_parity_error, w_framing_error, w_overrun_error}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sipo_rx.md
Name: sipo_rx

Overview:
- UART receive-side shift register. It is the partner of the transmit PISO.
- Oversamples the serial line, frames start + 8 data (LSB first) + parity + stop, and checks parity and stop.
- Presents the byte in parallel with a valid/acknowledge handshake toward the register/bus side of the UART.
- Sits between the pad-side data_rx line and the receive data register.

Parameters:
OVERSAMPLE, 16, baud_clk cycles per bit; even, at least 4.
DATA_BITS, 8, data bits per frame.

Ports:
baud_clk  input  1  clock, OVERSAMPLE x baud rate.
reset  input  1  synchronous, active-high reset.
data_rx  input  1  serial line, idles high; asynchronous to baud_clk.
parity_type  input  1  0 = even parity, 1 = odd parity; sampled at parity bit.
rd_ack  input  1  consumer has taken data_out; clears data_valid.
data_out  output  DATA_BITS  last received byte.
data_valid  output  1  high from frame completion until rd_ack.
done_flag  output  1  one-cycle pulse at each completed frame.
active_flag  output  1  high whenever the FSM is not IDLE.
parity_error  output  1  status of the last frame.
framing_error  output  1  status of the last frame; stop bit sampled low.
overrun_error  output  1  sticky; frame completed while data_valid was already high.
bit_count  output  4  data bits received in the current frame; observation only.

Behaviour:
- Input synchronizer: data_rx passes through a 2-flop synchronizer, reset value 1. All logic uses the synchronized value rx_s.
- Counters: tick_cnt is 0..OVERSAMPLE-1; bit_count is 0..DATA_BITS.
- FSM states are IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - rx_s==0 -> START, tick_cnt=0.
  - Otherwise hold.
- START:
  - At tick_cnt==OVERSAMPLE/2-1 (mid start bit), rx_s==0 -> DATA, tick_cnt=0, bit_count=0.
  - rx_s==1 at that point is a glitch or false start -> IDLE. No flags change.
- DATA:
  - At tick_cnt==OVERSAMPLE-1: shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]}, bit_count+1, tick_cnt=0.
  - After the DATA_BITS-th bit -> PARITY.
- PARITY:
  - At tick_cnt==OVERSAMPLE-1: par_err_next = rx_s XOR (^shift_reg) XOR parity_type.
  - Then -> STOP.
- STOP, at tick_cnt==OVERSAMPLE-1 (mid stop bit), all in the same cycle:
  - data_out <= shift_reg.
  - parity_error <= par_err_next; framing_error <= !rx_s.
  - done_flag=1 for this cycle.
  - overrun_error |= data_valid & !rd_ack; data_valid <= 1.
  - -> IDLE.
- Exit at mid stop bit is deliberate: it allows a back-to-back start bit to be caught.
- Framed with a framing error: byte is still delivered and data_valid is still set.
- Handshake:
  - rd_ack while data_valid clears data_valid next cycle.
  - rd_ack without data_valid is ignored.
  - Frame completion in the same cycle as rd_ack: data_valid stays 1, no overrun, data_out takes the new byte.
- Overrun: on overrun, data_out is overwritten by the new byte. overrun_error clears only on reset.
- Reset values:
  - FSM IDLE; all counters 0; shift_reg 0.
  - data_out 0; data_valid 0; done_flag 0; active_flag 0.
  - parity_error 0; framing_error 0; overrun_error 0; synchronizer 1.
- Reset mid-frame aborts the frame with no done_flag. The next falling edge after reset release starts a fresh frame.
- Latency: done_flag asserts (DATA_BITS+2.5)*OVERSAMPLE cycles after the data_rx falling edge, +2..3 cycles of sync/detect skew. This is 168 +2..3 for the defaults.
- Tolerance: a bit sampled at its centre tolerates roughly +/-4% baud mismatch for the defaults. No majority vote.

Test Plan:
1. Byte 0xA5, parity_type=0, parity bit 0, stop 1, 16 cycles/bit:
   - done_flag pulses once at 168+2..3 cycles.
   - data_out=0xA5, data_valid=1, parity_error=0, framing_error=0.
2. Byte 0x01 sent with parity bit 0, parity_type=1 (odd, expected 0):
   - parity_error=0.
   - Repeat with parity bit 1 -> parity_error=1, data_out=0x01.
3. Byte 0xFF with stop bit driven 0:
   - framing_error=1, data_out=0xFF, data_valid=1.
4. data_rx low pulse of 5 cycles, then high:
   - FSM returns to IDLE; no done_flag; data_valid unchanged; active_flag high for about 8 cycles only.
5. Two back-to-back frames 0x3C then 0xC3 with no rd_ack:
   - Second done_flag fires; data_out=0xC3, overrun_error=1.
   - Then rd_ack -> data_valid=0, overrun_error stays 1.
6. reset asserted 1 cycle at data bit 4 of a frame:
   - All outputs return to reset values; no done_flag.
   - A following clean frame 0x5A is received correctly with no errors.
